jtcps2_keyldr: RTL and testbench

//  Parametrised, double-buffered loader for the CPS2 decryption key. It takes the key as
//  an addressed byte stream from the ROM downloader (e.g. 20 bytes for CPS2) and builds it
//  in a working buffer. Only a complete, gap-free load is committed to a shadow register, so
//  the decoder never sees a partial key. Sits between the downloader and the CPS2 opcode decoder.

---
 rtl/jtcps2_keyldr_if.sv | 24 ++
 rtl/jtcps2_keyldr.sv | 103 ++++++++++
 tb/tb_jtcps2_keyldr.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/jtcps2_keyldr_if.sv
// Byte-stream and committed-key signals between the ROM downloader, the CPS2 key loader
// and the opcode decoder.
interface jtcps2_keyldr_if #(
    parameter int AW   = 5,
    parameter int SUMW = 12,
    parameter int KEYW = 64,
    parameter int RNGW = 16
);
    logic [7:0]      din;
    logic [AW-1:0]   din_addr;
    logic            din_we;
    logic            clr;
    logic [KEYW-1:0] key;
    logic [RNGW-1:0] addr_rng;
    logic            key_valid;
    logic            loading;
    logic [SUMW-1:0] sum;
    logic            err;

    modport master (output din, din_addr, din_we, clr,
                    input  key, addr_rng, key_valid, loading, sum, err);
    modport slave  (input  din, din_addr, din_we, clr,
                    output key, addr_rng, key_valid, loading, sum, err);
endinterface

// File: rtl/jtcps2_keyldr.sv
// Double-buffered CPS2 key loader: bytes build up in a working buffer and only a
// complete load is copied to the shadow that drives key/addr_rng.
module jtcps2_keyldr #(
    parameter int NBYTES = 20,
    parameter int AW     = 5,
    parameter int SUMW   = 12,
    parameter int KEYW   = 64,
    parameter int RNGW   = 16,
    parameter int ROT    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    jtcps2_keyldr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    localparam logic [AW:0] NB = NBYTES[AW:0];

    state_t              state;
    logic [8*NBYTES-1:0] raw;
    logic [NBYTES-1:0]   mask;
    logic [SUMW-1:0]     sum;
    logic [KEYW-1:0]     skey;
    logic [RNGW-1:0]     srng;
    logic                key_valid;
    logic                err;
    logic                last_we;

    logic                wr_ev;
    logic                in_rng;
    logic                wr_ok;
    logic                commit;
    logic [AW-1:0]       idx;
    logic [7:0]          old;
    logic [SUMW-1:0]     nsum;
    logic [KEYW-1:0]     key_rot;

    assign wr_ev  = bus.din_we && !last_we;
    assign in_rng = {1'b0, bus.din_addr} < NB;
    assign wr_ok  = wr_ev && in_rng && !bus.clr;
    assign idx    = in_rng ? bus.din_addr : '0;
    assign commit = (state == LOAD) && (&mask);

    // Stale raw bytes are invisible unless their mask bit is set; during COMMIT the
    // buffer is being emptied, so a write there starts from an empty sum.
    assign old  = (mask[idx] && state != COMMIT) ? raw[{idx, 3'b000} +: 8] : 8'h00;
    assign nsum = (state == COMMIT ? '0 : sum) + SUMW'(bus.din) - SUMW'(old);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            raw       <= '0;
            mask      <= '0;
            sum       <= '0;
            skey      <= '0;
            srng      <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            last_we   <= 1'b0;
        end else begin
            last_we <= bus.din_we;
            if (wr_ev && !in_rng) err <= 1'b1;

            // Shadow loads on the edge that leaves LOAD, one edge after the last byte
            if (commit) begin
                skey      <= raw[KEYW-1:0];
                srng      <= raw[8*NBYTES-1 -: RNGW];
                key_valid <= 1'b1;
            end

            case (state)
                IDLE:    if (wr_ok) state <= LOAD;
                LOAD:    if (commit) state <= COMMIT;
                COMMIT:  state <= wr_ok ? LOAD : IDLE;
                default: state <= IDLE;
            endcase
            if (bus.clr) state <= IDLE;

            if (bus.clr || state == COMMIT) begin
                mask <= '0;
                sum  <= '0;
            end
            if (wr_ok) begin
                raw[{idx, 3'b000} +: 8] <= bus.din;
                mask[idx]               <= 1'b1;
                sum                     <= nsum;
            end
        end
    end

    for (genvar k = 0; k < KEYW/16; k++) begin : g_word
        logic [15:0] w;
        assign w                    = skey[16*k +: 16];
        assign key_rot[16*k +: 16]  = (w << ROT) | (w >> (16 - ROT));
    end

    assign bus.key       = key_rot;
    assign bus.addr_rng  = srng;
    assign bus.key_valid = key_valid;
    assign bus.loading   = (state == LOAD);
    assign bus.sum       = sum;
    assign bus.err       = err;
endmodule

// File: tb/tb_jtcps2_keyldr.sv
// Directed bench for the CPS2 key loader: table of single-cycle vectors plus
// hand-written load, reload, clr and async-reset sequences.
module tb_jtcps2_keyldr;
    localparam logic [63:0] KEY1 = 64'h01C2_8141_00C1_8040;
    localparam logic [63:0] KEY2 = 64'hE9A9_6929_E8A8_6828;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    jtcps2_keyldr_if #(.AW(5), .SUMW(12), .KEYW(64), .RNGW(16)) bus();

    jtcps2_keyldr #(
        .NBYTES(20), .AW(5), .SUMW(12), .KEYW(64), .RNGW(16), .ROT(6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [7:0]  d;
        logic        clr;
        logic [11:0] sum;
        logic        loading;
        logic        err;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [7:0] d,
                         input logic c);
        bus.din_we   = we;
        bus.din_addr = a;
        bus.din      = d;
        bus.clr      = c;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        drive(1'b1, a, d, 1'b0);
        @(negedge clk);
        drive(1'b0, a, d, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd3,  8'hFF, 1'b0, 12'h0FF, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 5'd3,  8'hFF, 1'b0, 12'h0FF, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 5'd3,  8'hFF, 1'b0, 12'h0FF, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5'd3,  8'hFF, 1'b0, 12'h0FF, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 5'd3,  8'hFF, 1'b0, 12'h0FF, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'd3,  8'hFF, 1'b0, 12'h0FF, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 5'd3,  8'h00, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 5'd3,  8'h00, 1'b1, 12'h000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0,  8'h00, 1'b0, 12'h000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 5'd25, 8'h55, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'd25, 8'h55, 1'b0, 12'h000, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 5'd5,  8'h10, 1'b0, 12'h010, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 5'd5,  8'h10, 1'b0, 12'h010, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 5'd6,  8'h20, 1'b0, 12'h030, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 5'd6,  8'h20, 1'b1, 12'h000, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'd0,  8'h00, 1'b0, 12'h000, 1'b0, 1'b1};

        // Reset state
        drive(1'b0, 5'd0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst key",       bus.key,       64'h0);
        chk("rst addr_rng",  bus.addr_rng,  64'h0);
        chk("rst key_valid", bus.key_valid, 64'h0);
        chk("rst err",       bus.err,       64'h0);
        chk("rst loading",   bus.loading,   64'h0);
        chk("rst sum",       bus.sum,       64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sequential load 0x01..0x14, commit latency
        for (int i = 0; i < 19; i++) begin
            wr(5'(i), 8'(i + 1));
            if (i == 0) chk("load1 loading", bus.loading, 64'h1);
        end
        drive(1'b1, 5'd19, 8'h14, 1'b0);
        @(negedge clk);
        chk("load1 sum",        bus.sum,       64'h0D2);
        chk("load1 kv early",   bus.key_valid, 64'h0);
        chk("load1 loading",    bus.loading,   64'h1);
        drive(1'b0, 5'd19, 8'h14, 1'b0);
        @(negedge clk);
        chk("load1 kv",         bus.key_valid, 64'h1);
        chk("load1 key",        bus.key,       KEY1);
        chk("load1 word0",      bus.key[15:0], 64'h8040);
        chk("load1 addr_rng",   bus.addr_rng,  64'h1413);
        chk("load1 not loading", bus.loading,  64'h0);
        @(negedge clk);
        chk("load1 sum cleared", bus.sum,      64'h0);
        chk("load1 idle",       bus.loading,   64'h0);

        // Edge detect, rewrite, clr, out-of-range writes
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].d, tbl[i].clr);
            @(negedge clk);
            chk($sformatf("row%0d sum", i),     bus.sum,       64'(tbl[i].sum));
            chk($sformatf("row%0d loading", i), bus.loading,   64'(tbl[i].loading));
            chk($sformatf("row%0d err", i),     bus.err,       64'(tbl[i].err));
            chk($sformatf("row%0d key", i),     bus.key,       KEY1);
            chk($sformatf("row%0d kv", i),      bus.key_valid, 64'h1);
        end

        // Reload: old key held until the final byte lands
        for (int i = 1; i < 20; i++) wr(5'(i), 8'(8'hA0 + i));
        chk("reload key held",  bus.key,       KEY1);
        chk("reload rng held",  bus.addr_rng,  64'h1413);
        chk("reload loading",   bus.loading,   64'h1);
        chk("reload kv",        bus.key_valid, 64'h1);
        drive(1'b1, 5'd0, 8'hA0, 1'b0);
        @(negedge clk);
        chk("reload key n",     bus.key,       KEY1);
        chk("reload sum",       bus.sum,       64'hD3E);
        drive(1'b0, 5'd0, 8'hA0, 1'b0);
        @(negedge clk);
        chk("reload key n+1",   bus.key,       KEY2);
        chk("reload rng n+1",   bus.addr_rng,  64'hB3B2);
        @(negedge clk);

        // clr coincident with a write edge, 10 bytes loaded
        for (int i = 1; i <= 10; i++) wr(5'(i), 8'h11);
        chk("clr pre sum",      bus.sum,       64'h0AA);
        chk("clr pre loading",  bus.loading,   64'h1);
        drive(1'b1, 5'd0, 8'h77, 1'b1);
        @(negedge clk);
        chk("clr sum",          bus.sum,       64'h0);
        chk("clr loading",      bus.loading,   64'h0);
        chk("clr key kept",     bus.key,       KEY2);
        drive(1'b0, 5'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("clr byte dropped", bus.loading,   64'h0);
        chk("clr sum after",    bus.sum,       64'h0);

        // Asynchronous reset mid-load
        wr(5'd0, 8'h01);
        wr(5'd1, 8'h02);
        chk("mid sum",          bus.sum,       64'h3);
        chk("mid loading",      bus.loading,   64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst key",         bus.key,       64'h0);
        chk("arst addr_rng",    bus.addr_rng,  64'h0);
        chk("arst key_valid",   bus.key_valid, 64'h0);
        chk("arst err",         bus.err,       64'h0);
        chk("arst loading",     bus.loading,   64'h0);
        chk("arst sum",         bus.sum,       64'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
